ifetch_seq: RTL and testbench
=============================

Name: ifetch_seq

Overview:
- Sequential instruction-fetch stage that sits directly upstream of the control decoder.
- Holds the PC and issues word reads to instruction memory over a req/ack handshake.
- Presents a stable Instruction, with Opcode and Function_opcode slices, to decode, control and execute until the downstream datapath commits via `advance`.
- Computes the next PC from the branch/jump signals the decoder produces: Branch, nBranch, Jmp, Jal, Jr.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- IMEM_AW, 14, instruction memory word-address width.
- MAX_WAIT, 15, REQ cycles without ack before the fetch is retried.

Ports:
- clock  in  1  system clock; rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  IMEM_AW  word address = PC[IMEM_AW+1:2].
- imem_ack  in  1  memory ack; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- advance  in  1  downstream commit strobe for the current instruction.
- Branch  in  1  beq decoded.
- nBranch  in  1  bne decoded.
- Jmp  in  1  j decoded.
- Jal  in  1  jal decoded.
- Jr  in  1  jr decoded.
- Zero  in  1  ALU zero flag.
- Addr_result  in  32  branch target from execute.
- Read_data_1  in  32  rs value; jr target.
- Instruction  out  32  registered current instruction.
- Opcode  out  6  Instruction[31:26].
- Function_opcode  out  6  Instruction[5:0].
- inst_valid  out  1  Instruction is valid and held.
- PC  out  32  address of the current instruction.
- link_addr  out  32  return address written by jal.
- fetch_err  out  1  one-cycle pulse on a fetch timeout.

Behaviour:
- Reset (rst_n=0, asynchronous) drives these values immediately, independent of clock:
  - PC=PC_RESET; Instruction=0; inst_valid=0; imem_req=0; link_addr=0; fetch_err=0.
  - State=IDLE; wait counter=0.
- States are IDLE, REQ, HOLD, RETRY.
- IDLE:
  - Entered only from reset.
  - Moves to REQ on the first rising edge with rst_n=1.
  - imem_ack is ignored here.
- REQ:
  - imem_req=1; imem_addr is driven combinationally from the PC register and is stable while imem_req=1.
  - On an edge with imem_ack=1: Instruction<=imem_rdata, inst_valid<=1, imem_req<=0, counter<=0, go to HOLD.
  - Otherwise the counter increments. When it reaches MAX_WAIT: fetch_err<=1 for one cycle, imem_req<=0, counter<=0, go to RETRY.
- RETRY:
  - imem_req=0 for exactly one cycle, then REQ with the same PC.
  - imem_ack is ignored here.
- HOLD:
  - inst_valid=1; Instruction, Opcode, Function_opcode and PC are held stable.
  - On an edge with advance=1: PC<=next_pc, inst_valid<=0, go to REQ.
  - advance in any other state is ignored.
- next_pc is evaluated from the control inputs sampled on the advance edge, in this priority:
  1. Jr: Read_data_1 with bits[1:0] forced to 00.
  2. Jmp or Jal: {pc4[31:28], Instruction[25:0], 2'b00}.
  3. (Branch && Zero) || (nBranch && !Zero): Addr_result with bits[1:0] forced to 00.
  4. Otherwise pc4.
- pc4 = PC+4 with modulo-2^32 wrap (0xFFFFFFFC -> 0x00000000).
- Jal on the advance edge also loads link_addr<=pc4. link_addr is unchanged otherwise.
- Simultaneous illegal combinations resolve by the priority above, with no error flag.
- Latency:
  - The earliest ack is sampled one edge after req rises.
  - Minimum period is 2 cycles per instruction when ack is immediate and advance is asserted on the first HOLD cycle.
- Reset asserted mid-fetch or mid-HOLD aborts immediately. A late ack after release is ignored, since the block is in IDLE.
- imem_ack in HOLD or IDLE has no effect.

Test Plan:
- Reset release, memory acks 1 cycle after req, advance on first HOLD cycle -> imem_addr 0,1,2; PC 0x0,0x4,0x8; inst_valid toggles with a 2-cycle period.
- HOLD at PC=0x10, Instruction=0x08000040 (j), Jmp=1, advance -> next imem_addr=0x40, PC=0x100.
- PC=0x20, Jal=1, Instruction=0x0C000010, advance -> PC=0x40, link_addr=0x24.
- PC=0x30: (a) Branch=1, Zero=1, Addr_result=0x80 -> PC=0x80. (b) Branch=1, Zero=0 -> PC=0x34. (c) nBranch=1, Zero=0, Addr_result=0x80 -> PC=0x80. (d) Jr=1 with Jmp=1, Read_data_1=0x203 -> PC=0x200.
- Ack withheld 15 cycles -> fetch_err pulses once; req low 1 cycle then reasserted with the same address. Ack on retry -> Instruction captured, no further error.
- rst_n dropped while in REQ with ack arriving next cycle -> outputs reset at once; after release: IDLE, then REQ at PC_RESET, the stale ack is not captured, and inst_valid stays 0.
- PC=0xFFFFFFFC, no jump/branch, advance -> PC=0x00000000.

Source files
------------

// File: rtl/ifetch_seq.sv
// ifetch_seq: sequential instruction-fetch stage.
// Holds the PC, fetches one word per instruction over a req/ack handshake,
// holds the fetched instruction for decode until the datapath commits it, and
// then computes the next PC from the decoder's branch/jump controls.
module ifetch_seq #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          IMEM_AW  = 14,
  parameter int          MAX_WAIT = 15
) (
  input  logic               clock,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  input  logic               advance,
  input  logic               Branch,
  input  logic               nBranch,
  input  logic               Jmp,
  input  logic               Jal,
  input  logic               Jr,
  input  logic               Zero,
  input  logic [31:0]        Addr_result,
  input  logic [31:0]        Read_data_1,
  output logic [31:0]        Instruction,
  output logic [5:0]         Opcode,
  output logic [5:0]         Function_opcode,
  output logic               inst_valid,
  output logic [31:0]        PC,
  output logic [31:0]        link_addr,
  output logic               fetch_err
);

  // Wait counter must be able to hold MAX_WAIT-1.
  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    RETRY = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CW-1:0]   wait_cnt_r;
  logic [31:0]     pc_r;
  logic [31:0]     instr_r;
  logic [31:0]     link_r;
  logic            valid_r;
  logic            req_r;
  logic            err_r;

  logic            ack_take_s;
  logic            timeout_s;
  logic            commit_s;
  logic            take_branch_s;
  logic [31:0]     pc4_s;
  logic [31:0]     next_pc_s;

  // Outputs are taken straight from registers.
  assign imem_req        = req_r;
  assign imem_addr       = pc_r[IMEM_AW+1:2];
  assign Instruction     = instr_r;
  assign Opcode          = instr_r[31:26];
  assign Function_opcode = instr_r[5:0];
  assign inst_valid      = valid_r;
  assign PC              = pc_r;
  assign link_addr       = link_r;
  assign fetch_err       = err_r;

  // State register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic and the per-edge event strobes (capture, timeout, commit).
  always_comb begin
    state_nxt_s = state_r;
    ack_take_s  = 1'b0;
    timeout_s   = 1'b0;
    commit_s    = 1'b0;
    case (state_r)
      IDLE: begin
        state_nxt_s = REQ;
      end
      REQ: begin
        if (imem_ack) begin
          ack_take_s  = 1'b1;
          state_nxt_s = HOLD;
        end else if (wait_cnt_r == CW'(MAX_WAIT - 1)) begin
          timeout_s   = 1'b1;
          state_nxt_s = RETRY;
        end else begin
          state_nxt_s = REQ;
        end
      end
      HOLD: begin
        if (advance) begin
          commit_s    = 1'b1;
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      RETRY: begin
        state_nxt_s = REQ;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Next-PC selection: Jr, then j/jal, then taken beq/bne, then sequential.
  always_comb begin
    pc4_s         = pc_r + 32'd4;
    take_branch_s = (Branch && Zero) || (nBranch && !Zero);
    next_pc_s     = pc4_s;
    if (Jr) begin
      next_pc_s = Read_data_1 & 32'hFFFF_FFFC;
    end else if (Jmp || Jal) begin
      next_pc_s = {pc4_s[31:28], instr_r[25:0], 2'b00};
    end else if (take_branch_s) begin
      next_pc_s = Addr_result & 32'hFFFF_FFFC;
    end else begin
      next_pc_s = pc4_s;
    end
  end

  // Datapath registers: request, wait counter, instruction, PC, link and error pulse.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      req_r      <= 1'b0;
      wait_cnt_r <= {CW{1'b0}};
      instr_r    <= 32'h0000_0000;
      valid_r    <= 1'b0;
      pc_r       <= PC_RESET;
      link_r     <= 32'h0000_0000;
      err_r      <= 1'b0;
    end else begin
      // Request is high exactly while the FSM sits in REQ.
      req_r <= (state_nxt_s == REQ);
      err_r <= timeout_s;

      if (ack_take_s || timeout_s) begin
        wait_cnt_r <= {CW{1'b0}};
      end else if (state_r == REQ) begin
        wait_cnt_r <= wait_cnt_r + CW'(1);
      end else begin
        wait_cnt_r <= {CW{1'b0}};
      end

      if (ack_take_s) begin
        instr_r <= imem_rdata;
        valid_r <= 1'b1;
      end else if (commit_s) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end

      if (commit_s) begin
        pc_r <= next_pc_s;
        if (Jal) begin
          link_r <= pc4_s;
        end else begin
          link_r <= link_r;
        end
      end else begin
        pc_r <= pc_r;
      end
    end
  end

endmodule

// File: tb/tb_ifetch_seq.sv
// Scoreboard bench for ifetch_seq: a driver acts as instruction memory and
// downstream datapath, a reference model tracks the architectural PC/link,
// and a monitor compares each request address and each held instruction.
module tb_ifetch_seq;

  localparam int AW = 14;
  localparam int MW = 15;
  localparam logic [31:0] PCR = 32'h0000_0000;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [31:0]   imem_rdata = 32'h0;
  logic          advance = 1'b0;
  logic          Branch = 1'b0, nBranch = 1'b0, Jmp = 1'b0, Jal = 1'b0, Jr = 1'b0, Zero = 1'b0;
  logic [31:0]   Addr_result = 32'h0, Read_data_1 = 32'h0;
  logic [31:0]   Instruction;
  logic [5:0]    Opcode, Function_opcode;
  logic          inst_valid;
  logic [31:0]   PC, link_addr;
  logic          fetch_err;

  ifetch_seq #(.PC_RESET(PCR), .IMEM_AW(AW), .MAX_WAIT(MW)) dut (
    .clock(clock), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .advance(advance),
    .Branch(Branch), .nBranch(nBranch), .Jmp(Jmp), .Jal(Jal), .Jr(Jr), .Zero(Zero),
    .Addr_result(Addr_result), .Read_data_1(Read_data_1),
    .Instruction(Instruction), .Opcode(Opcode), .Function_opcode(Function_opcode),
    .inst_valid(inst_valid), .PC(PC), .link_addr(link_addr), .fetch_err(fetch_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] link;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] addr_q[$];
  int            tests = 0;
  int            fails = 0;
  int            exp_err = 0;
  int            seen_err = 0;
  logic [31:0]   pc_m = PCR;
  logic [31:0]   link_m = 32'h0;
  logic [31:0]   instr_m = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor / scoreboard
  logic req_prev = 1'b0, valid_prev = 1'b0, cur_ok = 1'b0;
  exp_t cur;
  always @(negedge clock) begin
    if (rst_n) begin
      if (imem_req && !req_prev) begin
        if (addr_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL req_addr: got unexpected request at %h expected none", imem_addr);
        end else begin
          chk("req_addr", {18'd0, imem_addr}, {18'd0, addr_q.pop_front()});
        end
      end
      if (inst_valid && !valid_prev) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL capture: got unexpected instr %h expected none", Instruction);
          cur_ok = 1'b0;
        end else begin
          cur = exp_q.pop_front();
          cur_ok = 1'b1;
          chk("instr", Instruction, cur.instr);
          chk("pc", PC, cur.pc);
          chk("opcode", {26'd0, Opcode}, {26'd0, cur.instr[31:26]});
          chk("funct", {26'd0, Function_opcode}, {26'd0, cur.instr[5:0]});
          chk("link", link_addr, cur.link);
        end
      end else if (inst_valid && cur_ok) begin
        chk("hold_instr", Instruction, cur.instr);
        chk("hold_pc", PC, cur.pc);
      end
      if (!inst_valid) cur_ok = 1'b0;
      if (fetch_err) seen_err++;
      req_prev = imem_req;
      valid_prev = inst_valid;
    end else begin
      req_prev = 1'b0;
      valid_prev = 1'b0;
      cur_ok = 1'b0;
    end
  end

  // Memory side: answer the pending request after d cycles; d >= MW forces a timeout.
  task automatic fetch(input logic [31:0] ins, input int d);
    int dd;
    int n;
    exp_t e;
    dd = d;
    for (int r = 0; r < 4; r++) begin
      n = 0;
      while (!imem_req && n < 20) begin
        @(negedge clock);
        n++;
      end
      if (!imem_req) begin
        tests++; fails++;
        $display("FAIL req_wait: got no request expected imem_req within 20 cycles");
        return;
      end
      if (dd >= MW) begin
        repeat (MW) begin
          advance = 1'($urandom_range(0, 1));
          @(negedge clock);
        end
        advance = 1'b0;
        exp_err++;
        addr_q.push_back(pc_m[AW+1:2]);
        dd = $urandom_range(0, 3);
      end else begin
        repeat (dd) begin
          advance = 1'($urandom_range(0, 1));
          @(negedge clock);
        end
        imem_ack = 1'b1;
        imem_rdata = ins;
        e.pc = pc_m; e.instr = ins; e.link = link_m;
        exp_q.push_back(e);
        instr_m = ins;
        @(negedge clock);
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        advance = 1'b0;
        return;
      end
    end
  endtask

  // Downstream side: stay in HOLD h cycles (with ignored acks), then commit with controls.
  task automatic adv(input logic jr, input logic jmp, input logic jal, input logic br,
                     input logic nbr, input logic z, input logic [31:0] ares,
                     input logic [31:0] rd1, input int h);
    logic [31:0] pc4;
    repeat (h) begin
      imem_ack = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      @(negedge clock);
    end
    imem_ack = 1'b0;
    Jr = jr; Jmp = jmp; Jal = jal; Branch = br; nBranch = nbr; Zero = z;
    Addr_result = ares; Read_data_1 = rd1;
    advance = 1'b1;
    pc4 = pc_m + 32'd4;
    if (jal) link_m = pc4;
    if (jr) pc_m = {rd1[31:2], 2'b00};
    else if (jmp || jal) pc_m = {pc4[31:28], instr_m[25:0], 2'b00};
    else if ((br && z) || (nbr && !z)) pc_m = {ares[31:2], 2'b00};
    else pc_m = pc4;
    addr_q.push_back(pc_m[AW+1:2]);
    @(negedge clock);
    advance = 1'b0;
    Jr = 1'b0; Jmp = 1'b0; Jal = 1'b0; Branch = 1'b0; nBranch = 1'b0; Zero = 1'b0;
  endtask

  task automatic plain();
    adv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0);
  endtask

  task automatic jr_to(input logic [31:0] t);
    adv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, t, 0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_pc"}, PC, PCR);
    chk({tag, "_instr"}, Instruction, 32'h0);
    chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    chk({tag, "_link"}, link_addr, 32'h0);
    chk({tag, "_err"}, {31'd0, fetch_err}, 32'd0);
  endtask

  initial begin
    #1;
    reset_checks("por");
    addr_q.push_back(PCR[AW+1:2]);
    @(negedge clock);
    rst_n = 1'b1;

    // Back-to-back sequential fetches: PC 0,4,8
    fetch($urandom, 0); plain();
    fetch($urandom, 0); plain();
    fetch($urandom, 0); plain();
    // j at 0x10
    fetch($urandom, 0); jr_to(32'h10);
    fetch(32'h0800_0040, 0);
    adv(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0);
    // jal at 0x20
    fetch($urandom, 0); jr_to(32'h20);
    fetch(32'h0C00_0010, 1);
    adv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1);
    // branches at 0x30
    fetch($urandom, 0); jr_to(32'h30);
    fetch($urandom, 0); adv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h80, 32'h0, 0);
    fetch($urandom, 0); jr_to(32'h30);
    fetch($urandom, 0); adv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80, 32'h0, 0);
    fetch($urandom, 0); jr_to(32'h30);
    fetch($urandom, 0); adv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h80, 32'h0, 0);
    fetch($urandom, 0); jr_to(32'h30);
    fetch($urandom, 0); adv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80, 32'h203, 0);
    // timeout then retry
    fetch($urandom, MW); plain();
    // PC wrap
    fetch($urandom, 0); jr_to(32'hFFFF_FFFC);
    fetch($urandom, 0); plain();

    // Randomized traffic
    for (int i = 0; i < 120; i++) begin
      fetch($urandom, ($urandom_range(0, 9) == 0) ? MW : $urandom_range(0, 4));
      adv(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
          $urandom, $urandom, $urandom_range(0, 2));
    end

    // Reset mid-REQ with a stale ack around the release edge
    @(negedge clock);
    rst_n = 1'b0;
    #1;
    reset_checks("midrst");
    pc_m = PCR; link_m = 32'h0;
    addr_q.push_back(PCR[AW+1:2]);
    @(negedge clock);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    imem_ack = 1'b0;
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);
    chk("post_rst_addr", {18'd0, imem_addr}, {18'd0, PCR[AW+1:2]});
    repeat (3) begin
      chk("post_rst_valid", {31'd0, inst_valid}, 32'd0);
      @(negedge clock);
    end
    fetch(32'h1234_5678, 0);
    repeat (3) @(negedge clock);

    chk("err_pulses", seen_err, exp_err);
    chk("addr_q_empty", addr_q.size(), 32'd0);
    chk("exp_q_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish within 500000 time units");
    $fatal(1, "watchdog");
  end

endmodule
